uart_rx_fifo: RTL and testbench

Synchronous, parametrised receive buffer between the UART receiver and the host/register interface. It replaces the edge-triggered pointer-reset FIFO with a true circular buffer: wrap-around pointers, exact occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a flush control. BIST_Mode blocks receiver writes so the self-test path can drain the buffer without new receive traffic mixing in.

---
 rtl/uart_pkg.sv | 15 +
 rtl/fifo_ram.sv | 25 ++
 rtl/uart_rx_fifo.sv | 85 ++++++++
 tb/tb_uart_rx_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults, pointer-width helpers and the status record for the UART receive FIFO
package uart_pkg;
  localparam int DATA_BITS_DEF  = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int ADDR_BITS_DEF  = $clog2(FIFO_DEPTH_DEF);
  localparam int CNT_BITS_DEF   = ADDR_BITS_DEF + 1;
  typedef struct packed {
    logic empty;
    logic full;
    logic afull;
    logic aempty;
    logic ovf;
    logic unf;
  } fifo_status_t;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage with a registered, reset-to-zero read port
// Ports: clk/rst_n clock and async active-low reset (read register only);
//        we/wa/wd write port; re/ra read request and address; rd registered read data (holds when re=0)
module fifo_ram #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int ADDR_BITS = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wa,
  input  logic [DATA_BITS-1:0] wd,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] ra,
  output logic [DATA_BITS-1:0] rd
);
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // a read and write to the same slot returns the old word, which is the oldest entry when full
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive buffer between the UART receiver and the host interface
// Ports: Clk, Rst_n (async active-low); Wr_En/Rx_Data receiver write; Rd_En read request;
//        Data_Out/Rd_Valid registered read data and its one-cycle strobe; Flush empties the buffer;
//        Clear_Errors clears sticky flags; BIST_Mode blocks writes; FIFO_* status flags; Count occupancy
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int ADDR_BITS    = $clog2(FIFO_DEPTH),
  localparam int CNT_BITS     = ADDR_BITS + 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Wr_En,
  input  logic [DATA_BITS-1:0] Rx_Data,
  input  logic                 Rd_En,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Rd_Valid,
  input  logic                 Flush,
  input  logic                 Clear_Errors,
  input  logic                 BIST_Mode,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Almost_Full,
  output logic                 FIFO_Almost_Empty,
  output logic                 FIFO_Overflow,
  output logic                 FIFO_Underflow,
  output logic [CNT_BITS-1:0]  Count
);
  logic [ADDR_BITS:0] wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0] cnt_nxt;
  fifo_status_t st, st_nxt;
  logic rd_acc, wr_acc, we, re, ovf_set, unf_set;
  // a full FIFO still accepts a write when a read frees a slot on the same edge
  always_comb begin
    rd_acc  = Rd_En & !st.empty;
    wr_acc  = Wr_En & !BIST_Mode & (!st.full | rd_acc);
    we      = wr_acc & !Flush;
    re      = rd_acc & !Flush;
    ovf_set = !Flush & Wr_En & !BIST_Mode & st.full & !rd_acc;
    unf_set = !Flush & Rd_En & st.empty;
    cnt_nxt = Flush ? '0 : Count + CNT_BITS'(wr_acc) - CNT_BITS'(rd_acc);
    st_nxt  = '{
      empty:  cnt_nxt == '0,
      full:   cnt_nxt == CNT_BITS'(FIFO_DEPTH),
      afull:  cnt_nxt >= CNT_BITS'(AFULL_THRESH),
      aempty: cnt_nxt <= CNT_BITS'(AEMPTY_THRESH),
      ovf:    (st.ovf & !Clear_Errors) | ovf_set,
      unf:    (st.unf & !Clear_Errors) | unf_set
    };
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Rd_Valid <= 1'b0;
      st       <= '{empty: 1'b1, aempty: 1'b1, default: 1'b0};
    end else begin
      wr_ptr   <= Flush ? '0 : wr_ptr + {{ADDR_BITS{1'b0}}, wr_acc};
      rd_ptr   <= Flush ? '0 : rd_ptr + {{ADDR_BITS{1'b0}}, rd_acc};
      Count    <= cnt_nxt;
      Rd_Valid <= re;
      st       <= st_nxt;
    end
  fifo_ram #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_ram (
    .clk(Clk),
    .rst_n(Rst_n),
    .we(we),
    .wa(wr_ptr[ADDR_BITS-1:0]),
    .wd(Rx_Data),
    .re(re),
    .ra(rd_ptr[ADDR_BITS-1:0]),
    .rd(Data_Out)
  );
  assign FIFO_Empty        = st.empty;
  assign FIFO_Full         = st.full;
  assign FIFO_Almost_Full  = st.afull;
  assign FIFO_Almost_Empty = st.aempty;
  assign FIFO_Overflow     = st.ovf;
  assign FIFO_Underflow    = st.unf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table plus queue-model scoreboard for the UART receive FIFO
module tb_uart_rx_fifo;
  logic Clk = 0, Rst_n = 0;
  logic Wr_En = 0, Rd_En = 0, Flush = 0, Clear_Errors = 0, BIST_Mode = 0;
  logic [7:0] Rx_Data = 0;
  logic [7:0] Data_Out;
  logic Rd_Valid, FIFO_Empty, FIFO_Full, FIFO_Almost_Full, FIFO_Almost_Empty;
  logic FIFO_Overflow, FIFO_Underflow;
  logic [4:0] Count;

  uart_rx_fifo dut (
    .Clk(Clk), .Rst_n(Rst_n), .Wr_En(Wr_En), .Rx_Data(Rx_Data), .Rd_En(Rd_En),
    .Data_Out(Data_Out), .Rd_Valid(Rd_Valid), .Flush(Flush), .Clear_Errors(Clear_Errors),
    .BIST_Mode(BIST_Mode), .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full),
    .FIFO_Almost_Full(FIFO_Almost_Full), .FIFO_Almost_Empty(FIFO_Almost_Empty),
    .FIFO_Overflow(FIFO_Overflow), .FIFO_Underflow(FIFO_Underflow), .Count(Count)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic m_ovf = 0, m_unf = 0, m_vld = 0;
  logic [7:0] m_dout = 0;
  int maxc;

  typedef struct {
    logic wr; logic [7:0] d; logic rd; logic clr;
    int cnt; logic vld; logic [7:0] dout; logic ovf; logic unf;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_count", Count, 0);
    chk("rst_dout", Data_Out, 0);
    chk("rst_valid", Rd_Valid, 0);
    chk("rst_empty", FIFO_Empty, 1);
    chk("rst_aempty", FIFO_Almost_Empty, 1);
    chk("rst_full", FIFO_Full, 0);
    chk("rst_afull", FIFO_Almost_Full, 0);
    chk("rst_ovf", FIFO_Overflow, 0);
    chk("rst_unf", FIFO_Underflow, 0);
  endtask

  task automatic model_reset();
    mq.delete(); sb.delete();
    m_ovf = 0; m_unf = 0; m_vld = 0; m_dout = 0;
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                      input logic fl, input logic clr, input logic bist);
    logic full, empty, ra, wa;
    @(negedge Clk);
    Wr_En = wr; Rx_Data = d; Rd_En = rd; Flush = fl; Clear_Errors = clr; BIST_Mode = bist;
    full  = mq.size() == 16;
    empty = mq.size() == 0;
    ra = rd & !empty;
    wa = wr & !bist & (!full | ra);
    m_vld = 0;
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (fl) mq.delete();
    else begin
      if (wr & !bist & full & !ra) m_ovf = 1;
      if (rd & empty) m_unf = 1;
      if (ra) begin m_dout = mq.pop_front(); sb.push_back(m_dout); m_vld = 1; end
      if (wa) mq.push_back(d);
    end
    @(posedge Clk);
    #1;
    chk("count", Count, mq.size());
    chk("empty", FIFO_Empty, int'(mq.size() == 0));
    chk("full", FIFO_Full, int'(mq.size() == 16));
    chk("afull", FIFO_Almost_Full, int'(mq.size() >= 14));
    chk("aempty", FIFO_Almost_Empty, int'(mq.size() <= 2));
    chk("ovf", FIFO_Overflow, m_ovf);
    chk("unf", FIFO_Underflow, m_unf);
    chk("rd_valid", Rd_Valid, m_vld);
    if (Rd_Valid && sb.size() > 0) chk("rd_data", Data_Out, sb.pop_front());
    else chk("dout_hold", Data_Out, m_dout);
    if (int'(Count) > maxc) maxc = int'(Count);
  endtask

  task automatic idle_inputs();
    @(negedge Clk);
    Wr_En = 0; Rd_En = 0; Flush = 0; Clear_Errors = 0; BIST_Mode = 0;
  endtask

  initial begin
    tbl[0] = '{1, 8'hA1, 0, 0, 1, 0, 8'h00, 0, 0};
    tbl[1] = '{1, 8'hA2, 0, 0, 2, 0, 8'h00, 0, 0};
    tbl[2] = '{0, 8'h00, 1, 0, 1, 1, 8'hA1, 0, 0};
    tbl[3] = '{1, 8'hA3, 1, 0, 1, 1, 8'hA2, 0, 0};
    tbl[4] = '{0, 8'h00, 0, 0, 1, 0, 8'hA2, 0, 0};
    tbl[5] = '{0, 8'h00, 1, 0, 0, 1, 8'hA3, 0, 0};
    tbl[6] = '{0, 8'h00, 1, 0, 0, 0, 8'hA3, 0, 1};
    tbl[7] = '{0, 8'h00, 0, 1, 0, 0, 8'hA3, 0, 0};

    #12;
    chk_reset_vals();
    @(negedge Clk); Rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rd, 0, tbl[i].clr, 0);
      chk("tbl_count", Count, tbl[i].cnt);
      chk("tbl_valid", Rd_Valid, tbl[i].vld);
      chk("tbl_dout", Data_Out, tbl[i].dout);
      chk("tbl_ovf", FIFO_Overflow, tbl[i].ovf);
      chk("tbl_unf", FIFO_Underflow, tbl[i].unf);
    end

    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0, 0, 0, 0);
      if (i == 13) chk("afull_13", FIFO_Almost_Full, 0);
      if (i == 14) chk("afull_14", FIFO_Almost_Full, 1);
    end
    chk("full_16", FIFO_Full, 1);
    step(1, 8'hAA, 0, 0, 0, 0);
    chk("ovf_17th", FIFO_Overflow, 1);
    chk("count_17th", Count, 16);

    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 0, 0, 0);
      chk("drain_data", Data_Out, i);
    end
    chk("empty_drained", FIFO_Empty, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("unf_empty_rd", FIFO_Underflow, 1);
    chk("dout_held_10", Data_Out, 8'h10);
    step(0, 0, 0, 0, 1, 0);

    maxc = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) step(1, 8'(8'h20 + r * 16 + i), 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0);
    end
    chk("wrap_max_count", maxc, 10);

    for (int i = 0; i < 16; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
    step(1, 8'h55, 1, 0, 0, 0);
    chk("full_rw_count", Count, 16);
    chk("full_rw_oldest", Data_Out, 8'h60);
    chk("full_rw_no_ovf", FIFO_Overflow, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 0);
    chk("full_rw_last", Data_Out, 8'h55);

    step(1, 8'h33, 1, 0, 0, 0);
    chk("empty_rw_unf", FIFO_Underflow, 1);
    chk("empty_rw_count", Count, 1);
    chk("empty_rw_novalid", Rd_Valid, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("empty_rw_data", Data_Out, 8'h33);

    for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 0, 0, 0, 0);
    step(1, 8'h77, 0, 1, 0, 0);
    chk("flush_count", Count, 0);
    chk("flush_empty", FIFO_Empty, 1);
    chk("flush_unf_kept", FIFO_Underflow, 1);

    for (int i = 0; i < 3; i++) step(1, 8'hB0, 0, 0, 0, 1);
    chk("bist_count", Count, 0);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0, 0, 0);
    step(1, 8'hBB, 0, 0, 0, 1);
    chk("bist_full_no_ovf", FIFO_Overflow, 0);
    step(0, 0, 1, 0, 0, 1);
    chk("bist_read_ok", Data_Out, 8'h80);

    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 1, 0, 0, 0);
    @(negedge Clk);
    #2 Rst_n = 0;
    #1;
    chk_reset_vals();
    model_reset();
    idle_inputs();
    Rst_n = 1;
    step(1, 8'hD1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("post_rst_data", Data_Out, 8'hD1);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
